// File: rtl/mux_16x1_pkg.sv
// Shared widths and latency for the registered 16-to-1 mux.
// Latency depends on the optional MUX_16X1_IN_REG_EN input register stage.
package mux_16x1_pkg;

   localparam int DATA_W = 16;
   localparam int SEL_W  = 4;

`ifdef MUX_16X1_IN_REG_EN
   localparam int LATENCY = 2;
`else
   localparam int LATENCY = 1;
`endif

endpackage

// File: rtl/mux_16x1_if.sv
// Data/select/valid bundle for mux_16x1.
// The master side drives i, s and in_valid; the slave side returns y and out_valid.
interface mux_16x1_if;
   import mux_16x1_pkg::*;

   logic [DATA_W-1:0] i;
   logic [SEL_W-1:0]  s;
   logic              in_valid;
   logic              y;
   logic              out_valid;

   modport master (output i, output s, output in_valid, input y, input out_valid);
   modport slave  (input i, input s, input in_valid, output y, output out_valid);

endinterface

// File: rtl/mux_16x1_mux_4x1.sv
// Combinational 4-to-1 single-bit mux, used as leaf and root of the 16-to-1 tree.
module mux_4x1 (
   input  logic [3:0] d,
   input  logic [1:0] sel,
   output logic       y
);

   assign y = d[sel];

endmodule

// File: rtl/mux_16x1.sv
// Registered 16-to-1 mux: optional input stage (MUX_16X1_IN_REG_EN), a two-level
// tree of mux_4x1 instances, then the output register and valid flag.
module mux_16x1
   import mux_16x1_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   mux_16x1_if.slave   bus
);

   logic [DATA_W-1:0] tree_data;
   logic [SEL_W-1:0]  tree_sel;
   logic              tree_valid;
   logic [3:0]        leaf_y;
   logic              root_y;
   logic              y_q;
   logic              valid_q;

`ifdef MUX_16X1_IN_REG_EN
   logic [DATA_W-1:0] data_q;
   logic [SEL_W-1:0]  sel_q;
   logic              in_valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q     <= '0;
         sel_q      <= '0;
         in_valid_q <= 1'b0;
      end else begin
         data_q     <= bus.i;
         sel_q      <= bus.s;
         in_valid_q <= bus.in_valid;
      end
   end

   assign tree_data  = data_q;
   assign tree_sel   = sel_q;
   assign tree_valid = in_valid_q;
`else
   assign tree_data  = bus.i;
   assign tree_sel   = bus.s;
   assign tree_valid = bus.in_valid;
`endif

   for (genvar g = 0; g < 4; g++) begin : g_leaf
      mux_4x1 u_leaf (
         .d   (tree_data[4*g +: 4]),
         .sel (tree_sel[1:0]),
         .y   (leaf_y[g])
      );
   end

   mux_4x1 u_root (
      .d   (leaf_y),
      .sel (tree_sel[3:2]),
      .y   (root_y)
   );

   // y only moves on an accepted sample, so it holds across idle cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q     <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= tree_valid;
         if (tree_valid) begin
            y_q <= root_y;
         end
      end
   end

   assign bus.y         = y_q;
   assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_mux_16x1.sv
// Self-checking bench for mux_16x1: table-driven sweep/walking vectors plus
// hand-written reset, hold, mid-stream reset and don't-care sequences.
module tb_mux_16x1;
   import mux_16x1_pkg::*;

   typedef struct {
      logic [15:0] i;
      logic [3:0]  s;
      logic        exp_y;
   } vec_t;

   localparam int NVEC = 48;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   vec_t vecs [NVEC];

   mux_16x1_if bus ();

   mux_16x1 u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic actual, input logic expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%b required=%b at %0t", name, actual, expected, $time);
      end
   endtask

   // drive one cycle of inputs at the falling edge, return just after the rising edge
   task automatic apply_stimulus(input logic [15:0] iv, input logic [3:0] sv, input logic v);
      @(negedge clk);
      bus.i        = iv;
      bus.s        = sv;
      bus.in_valid = v;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [0:15] sweep_exp;
      logic [15:0] sweep_i;
      logic [15:0] xv;
      checks = 0;
      errors = 0;

      sweep_i   = 16'b0110101000011101;
      sweep_exp = 16'b1011100001010110;
      for (int k = 0; k < 16; k++) begin
         vecs[k]    = '{i: sweep_i, s: 4'(k), exp_y: sweep_exp[k]};
         vecs[16+k] = '{i: 16'h0001 << k, s: 4'(k), exp_y: 1'b1};
         vecs[32+k] = '{i: ~(16'h0001 << k), s: 4'(k), exp_y: 1'b0};
      end

      // reset held with a live input
      rst_n        = 1'b0;
      bus.i        = 16'hFFFF;
      bus.s        = 4'd0;
      bus.in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_y", bus.y, 1'b0);
      check_output("reset_out_valid", bus.out_valid, 1'b0);

      @(negedge clk);
      rst_n = 1'b1;
      repeat (LATENCY) @(posedge clk);
      #1;
      check_output("first_capture_y", bus.y, 1'b1);
      check_output("first_capture_out_valid", bus.out_valid, 1'b1);

      // asynchronous assertion between edges
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("async_reset_y", bus.y, 1'b0);
      check_output("async_reset_out_valid", bus.out_valid, 1'b0);
      @(negedge clk);
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;

      // back-to-back table stream
      for (int n = 0; n < NVEC + LATENCY - 1; n++) begin
         int k;
         if (n < NVEC) apply_stimulus(vecs[n].i, vecs[n].s, 1'b1);
         else          apply_stimulus(16'h0000, 4'd0, 1'b0);
         k = n - LATENCY + 1;
         if (k >= 0) begin
            check_output($sformatf("vec%0d_y", k), bus.y, vecs[k].exp_y);
            check_output($sformatf("vec%0d_out_valid", k), bus.out_valid, 1'b1);
         end else begin
            check_output($sformatf("prefill%0d_out_valid", n), bus.out_valid, 1'b0);
         end
      end
      apply_stimulus(16'h0000, 4'd0, 1'b0);
      check_output("stream_end_out_valid", bus.out_valid, 1'b0);

      // hold: idle cycles with changing i and s must not disturb y
      apply_stimulus(16'h0001, 4'd0, 1'b1);
      repeat (LATENCY - 1) apply_stimulus(16'($urandom), 4'($urandom), 1'b0);
      check_output("hold_capture_y", bus.y, 1'b1);
      for (int c = 0; c < 10; c++) begin
         apply_stimulus(16'($urandom), 4'($urandom), 1'b0);
         check_output($sformatf("hold%0d_y", c), bus.y, 1'b1);
         check_output($sformatf("hold%0d_out_valid", c), bus.out_valid, 1'b0);
      end

      // mid-stream reset flushes in-flight samples
      for (int k = 0; k < 3; k++) apply_stimulus(16'hFFFF, 4'(k), 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_output("midrst_async_y", bus.y, 1'b0);
      check_output("midrst_async_out_valid", bus.out_valid, 1'b0);
      @(posedge clk);
      #1;
      check_output("midrst_held_out_valid", bus.out_valid, 1'b0);
      @(negedge clk);
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      for (int c = 0; c < LATENCY + 1; c++) begin
         apply_stimulus(16'hFFFF, 4'd0, 1'b0);
         check_output($sformatf("flushed%0d_out_valid", c), bus.out_valid, 1'b0);
      end
      apply_stimulus(16'h8000, 4'd15, 1'b1);
      repeat (LATENCY - 1) apply_stimulus(16'h0000, 4'd0, 1'b0);
      check_output("resume_y", bus.y, 1'b1);
      check_output("resume_out_valid", bus.out_valid, 1'b1);
      apply_stimulus(16'h0000, 4'd0, 1'b0);
      check_output("resume_end_out_valid", bus.out_valid, 1'b0);

      // unknown bits outside the selected position
      xv    = 16'hxxxx;
      xv[1] = 1'b0;
      apply_stimulus(xv, 4'd1, 1'b1);
      repeat (LATENCY - 1) apply_stimulus(16'h0000, 4'd0, 1'b0);
      check_output("xdata_sel1_y", bus.y, 1'b0);
      xv     = 16'hxxxx;
      xv[14] = 1'b1;
      apply_stimulus(xv, 4'd14, 1'b1);
      repeat (LATENCY - 1) apply_stimulus(16'h0000, 4'd0, 1'b0);
      check_output("xdata_sel14_y", bus.y, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
